io_side_ctrl: RTL and testbench



---
 rtl/io_side_ctrl_if.sv | 30 +++
 rtl/io_side_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_io_side_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_side_ctrl_if.sv
// ---------------------------------------------------------------------------
// io_side_ctrl_if
// Single-outstanding request/response register port for io_side_ctrl.
//   req_valid/req_ready : request handshake (master -> slave)
//   req_write           : 1 = write, 0 = read
//   req_addr  [3:0]     : register index
//   req_wdata [31:0]    : write data
//   resp_valid/resp_ready : response handshake (slave -> master)
//   resp_rdata [31:0]   : read data (0 for writes)
// ---------------------------------------------------------------------------
interface io_side_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [3:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/io_side_ctrl.sv
// ---------------------------------------------------------------------------
// io_side_ctrl
// Core-side controller for one padring side. Owns per-pin dout / oen / ie
// and tech_cfg slices, synchronizes returning pad data, captures rising and
// falling edges into sticky status bits and raises a level interrupt.
// Ports:
//   clk, nreset       : clock, synchronous active-low reset
//   bus (slave)       : register request/response port
//   din      [NPINS]  : asynchronous pad input data
//   dout     [NPINS]  : pad output data
//   oen      [NPINS]  : pad output enable, active low
//   ie       [NPINS]  : pad input enable
//   tech_cfg [NPINS*CFGW] : per-pad config, pin i at [i*CFGW +: CFGW]
//   irq               : level interrupt, registered
// ---------------------------------------------------------------------------
module io_side_ctrl #(
   parameter int NPINS = 9,
   parameter int CFGW  = 18
) (
   input  logic                    clk,
   input  logic                    nreset,
   io_side_ctrl_if.slave           bus,
   input  logic [NPINS-1:0]        din,
   output logic [NPINS-1:0]        dout,
   output logic [NPINS-1:0]        oen,
   output logic [NPINS-1:0]        ie,
   output logic [NPINS*CFGW-1:0]   tech_cfg,
   output logic                    irq
);

   localparam logic [3:0] ADDR_DOUT     = 4'd0;
   localparam logic [3:0] ADDR_OEN      = 4'd1;
   localparam logic [3:0] ADDR_IE       = 4'd2;
   localparam logic [3:0] ADDR_DIN      = 4'd3;
   localparam logic [3:0] ADDR_RISE     = 4'd4;
   localparam logic [3:0] ADDR_FALL     = 4'd5;
   localparam logic [3:0] ADDR_INTEN    = 4'd6;
   localparam logic [3:0] ADDR_CFG_IDX  = 4'd7;
   localparam logic [3:0] ADDR_CFG_DATA = 4'd8;
   localparam logic [3:0] NPINS_IDX     = 4'(NPINS);
   localparam logic [3:0] LAST_IDX      = 4'(NPINS - 1);

   logic [NPINS-1:0]      dout_r;
   logic [NPINS-1:0]      oen_r;
   logic [NPINS-1:0]      ie_r;
   logic [NPINS*CFGW-1:0] tech_cfg_r;
   logic [NPINS-1:0]      rise_r;
   logic [NPINS-1:0]      fall_r;
   logic [NPINS-1:0]      inten_r;
   logic [3:0]            cfg_idx_r;
   logic [NPINS-1:0]      sync_r;
   logic [NPINS-1:0]      din_s_r;
   logic [NPINS-1:0]      din_p_r;
   logic [1:0]            start_cnt_r;
   logic                  irq_r;
   logic                  resp_valid_r;
   logic [31:0]           resp_rdata_r;

   logic                  accept_s;
   logic                  edge_en_s;
   logic [NPINS-1:0]      wdata_pins_s;
   logic [NPINS-1:0]      rise_s;
   logic [NPINS-1:0]      fall_s;
   logic [NPINS-1:0]      rise_clr_s;
   logic [NPINS-1:0]      fall_clr_s;
   logic [CFGW-1:0]       cfg_slice_s;
   logic [31:0]           rdata_s;
   logic                  unused_s;

   // Only one request may be outstanding: accept only while no response is held.
   assign accept_s        = bus.req_valid & ~resp_valid_r;
   assign bus.req_ready   = ~resp_valid_r;
   assign bus.resp_valid  = resp_valid_r;
   assign bus.resp_rdata  = resp_rdata_r;

   assign dout     = dout_r;
   assign oen      = oen_r;
   assign ie       = ie_r;
   assign tech_cfg = tech_cfg_r;
   assign irq      = irq_r;

   assign wdata_pins_s = bus.req_wdata[NPINS-1:0];
   assign unused_s     = ^bus.req_wdata[31:CFGW];

   // Edges are ignored until the pipeline has been filled with real pad data,
   // so the reset values of the sync flops never look like transitions.
   assign edge_en_s = (start_cnt_r == 2'd3);
   assign rise_s    = din_s_r & ~din_p_r & ie_r & {NPINS{edge_en_s}};
   assign fall_s    = ~din_s_r & din_p_r & ie_r & {NPINS{edge_en_s}};

   // Write-1-to-clear masks for the sticky status registers.
   always_comb begin
      rise_clr_s = {NPINS{1'b0}};
      fall_clr_s = {NPINS{1'b0}};
      if (accept_s && bus.req_write && (bus.req_addr == ADDR_RISE)) begin
         rise_clr_s = wdata_pins_s;
      end else if (accept_s && bus.req_write && (bus.req_addr == ADDR_FALL)) begin
         fall_clr_s = wdata_pins_s;
      end else begin
         rise_clr_s = {NPINS{1'b0}};
         fall_clr_s = {NPINS{1'b0}};
      end
   end

   // Select the tech_cfg slice addressed by CFG_IDX for reads.
   always_comb begin
      cfg_slice_s = {CFGW{1'b0}};
      for (int i = 0; i < NPINS; i++) begin
         cfg_slice_s = cfg_slice_s |
                       ((cfg_idx_r == 4'(i)) ? tech_cfg_r[i*CFGW +: CFGW] : {CFGW{1'b0}});
      end
   end

   // Read data mux; unused upper bits and unmapped addresses read as zero.
   always_comb begin
      rdata_s = 32'd0;
      case (bus.req_addr)
         ADDR_DOUT:     rdata_s[NPINS-1:0] = dout_r;
         ADDR_OEN:      rdata_s[NPINS-1:0] = oen_r;
         ADDR_IE:       rdata_s[NPINS-1:0] = ie_r;
         ADDR_DIN:      rdata_s[NPINS-1:0] = din_s_r;
         ADDR_RISE:     rdata_s[NPINS-1:0] = rise_r;
         ADDR_FALL:     rdata_s[NPINS-1:0] = fall_r;
         ADDR_INTEN:    rdata_s[NPINS-1:0] = inten_r;
         ADDR_CFG_IDX:  rdata_s[3:0]       = cfg_idx_r;
         ADDR_CFG_DATA: rdata_s[CFGW-1:0]  = cfg_slice_s;
         default:       rdata_s            = 32'd0;
      endcase
   end

   // All state: pad control registers, input path, status, irq and bus response.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         dout_r       <= {NPINS{1'b0}};
         oen_r        <= {NPINS{1'b1}};
         ie_r         <= {NPINS{1'b1}};
         tech_cfg_r   <= {(NPINS*CFGW){1'b0}};
         rise_r       <= {NPINS{1'b0}};
         fall_r       <= {NPINS{1'b0}};
         inten_r      <= {NPINS{1'b0}};
         cfg_idx_r    <= 4'd0;
         sync_r       <= {NPINS{1'b0}};
         din_s_r      <= {NPINS{1'b0}};
         din_p_r      <= {NPINS{1'b0}};
         start_cnt_r  <= 2'd0;
         irq_r        <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'd0;
      end else begin
         sync_r  <= din;
         din_s_r <= sync_r;
         din_p_r <= din_s_r;
         if (start_cnt_r != 2'd3) begin
            start_cnt_r <= start_cnt_r + 2'd1;
         end

         // A new edge in the same cycle as a clear keeps the bit set.
         rise_r <= (rise_r & ~rise_clr_s) | rise_s;
         fall_r <= (fall_r & ~fall_clr_s) | fall_s;
         irq_r  <= |((rise_r | fall_r) & inten_r);

         if (accept_s) begin
            resp_valid_r <= 1'b1;
            resp_rdata_r <= bus.req_write ? 32'd0 : rdata_s;
            if (bus.req_write) begin
               case (bus.req_addr)
                  ADDR_DOUT:  dout_r  <= wdata_pins_s;
                  ADDR_OEN:   oen_r   <= wdata_pins_s;
                  ADDR_IE:    ie_r    <= wdata_pins_s;
                  ADDR_INTEN: inten_r <= wdata_pins_s;
                  ADDR_CFG_IDX: begin
                     if (bus.req_wdata[3:0] < NPINS_IDX) begin
                        cfg_idx_r <= bus.req_wdata[3:0];
                     end
                  end
                  ADDR_CFG_DATA: begin
                     for (int i = 0; i < NPINS; i++) begin
                        if (cfg_idx_r == 4'(i)) begin
                           tech_cfg_r[i*CFGW +: CFGW] <= bus.req_wdata[CFGW-1:0];
                        end
                     end
                     cfg_idx_r <= (cfg_idx_r == LAST_IDX) ? 4'd0 : cfg_idx_r + 4'd1;
                  end
                  // RISE/FALL go through the clear masks; DIN and holes ignore writes.
                  default: ;
               endcase
            end
         end else if (resp_valid_r && bus.resp_ready) begin
            resp_valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_io_side_ctrl.sv
module tb_io_side_ctrl;
   localparam int NPINS = 9;
   localparam int CFGW  = 18;

   logic                  clk = 1'b0;
   logic                  nreset = 1'b0;
   logic [NPINS-1:0]      din = '1;
   logic [NPINS-1:0]      dout;
   logic [NPINS-1:0]      oen;
   logic [NPINS-1:0]      ie;
   logic [NPINS*CFGW-1:0] tech_cfg;
   logic                  irq;

   io_side_ctrl_if bus_if();

   io_side_ctrl #(.NPINS(NPINS), .CFGW(CFGW)) dut (
      .clk(clk), .nreset(nreset), .bus(bus_if), .din(din), .dout(dout),
      .oen(oen), .ie(ie), .tech_cfg(tech_cfg), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural register model
   logic [8:0]  m_dout, m_oen, m_ie, m_rise, m_fall, m_inten;
   logic [3:0]  m_idx;
   logic [17:0] m_cfg [9];

   task automatic model_reset();
      m_dout = 9'h000; m_oen = 9'h1FF; m_ie = 9'h1FF;
      m_rise = 9'h000; m_fall = 9'h000; m_inten = 9'h000; m_idx = 4'd0;
      for (int i = 0; i < 9; i++) m_cfg[i] = 18'h0;
   endtask

   task automatic model_write(input logic [3:0] a, input logic [31:0] d);
      case (a)
         4'd0: m_dout  = d[8:0];
         4'd1: m_oen   = d[8:0];
         4'd2: m_ie    = d[8:0];
         4'd4: m_rise  = m_rise & ~d[8:0];
         4'd5: m_fall  = m_fall & ~d[8:0];
         4'd6: m_inten = d[8:0];
         4'd7: if (d[3:0] < 4'd9) m_idx = d[3:0];
         4'd8: begin
            m_cfg[m_idx] = d[17:0];
            m_idx = 4'((32'(m_idx) + 1) % 9);
         end
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a);
      logic [31:0] r;
      r = 32'h0;
      case (a)
         4'd0: r[8:0] = m_dout;
         4'd1: r[8:0] = m_oen;
         4'd2: r[8:0] = m_ie;
         4'd3: r[8:0] = din;
         4'd4: r[8:0] = m_rise;
         4'd5: r[8:0] = m_fall;
         4'd6: r[8:0] = m_inten;
         4'd7: r[3:0] = m_idx;
         4'd8: r[17:0] = m_cfg[m_idx];
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic [161:0] model_cfg_vec();
      logic [161:0] v;
      for (int i = 0; i < 9; i++) v[i*18 +: 18] = m_cfg[i];
      return v;
   endfunction

   function automatic logic model_irq();
      return |((m_rise | m_fall) & m_inten);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Change pad inputs, record the edges the spec rules imply, let them settle.
   task automatic set_din(input logic [8:0] v);
      m_rise = m_rise | (v & ~din & m_ie);
      m_fall = m_fall | (~v & din & m_ie);
      din = v;
      for (int k = 0; k < 5; k++) tick();
   endtask

   // Present a request and return right after the accepting edge.
   task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
      logic rdy;
      logic got;
      got = 1'b0;
      bus_if.req_valid = 1'b1; bus_if.req_write = w;
      bus_if.req_addr = a; bus_if.req_wdata = d;
      for (int k = 0; k < 20; k++) begin
         rdy = bus_if.req_ready;
         tick();
         if (rdy) begin got = 1'b1; break; end
      end
      bus_if.req_valid = 1'b0;
      rd = bus_if.resp_rdata;
      if (got) begin
         if (w) model_write(a, d);
      end else begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout: addr %0d not accepted within 20 cycles", a);
      end
   endtask

   task automatic complete();
      bus_if.resp_ready = 1'b1;
      tick();
   endtask

   task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
      send(w, a, d, rd);
      complete();
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      nreset = 1'b0; din = 9'h1FF;
      for (int k = 0; k < 2; k++) begin
         bus_if.req_valid  = 1'($urandom_range(0, 1));
         bus_if.req_write  = 1'($urandom_range(0, 1));
         bus_if.req_addr   = 4'($urandom_range(0, 15));
         bus_if.req_wdata  = $urandom;
         bus_if.resp_ready = 1'($urandom_range(0, 1));
         tick();
      end
      bus_if.req_valid = 1'b0; bus_if.resp_ready = 1'b1;
      n_checks++; if (oen !== 9'h1FF) begin n_fail++; $display("FAIL rst_oen: got %h exp 1ff", oen); end
      n_checks++; if (ie !== 9'h1FF) begin n_fail++; $display("FAIL rst_ie: got %h exp 1ff", ie); end
      n_checks++; if (dout !== 9'h000) begin n_fail++; $display("FAIL rst_dout: got %h exp 000", dout); end
      n_checks++; if (tech_cfg !== '0) begin n_fail++; $display("FAIL rst_cfg: got %h exp 0", tech_cfg); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b exp 0", irq); end
      n_checks++; if (bus_if.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b exp 0", bus_if.resp_valid); end
      n_checks++; if (bus_if.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", bus_if.resp_rdata); end
      nreset = 1'b1;
      model_reset();
      for (int k = 0; k < 6; k++) tick();
      xfer(1'b0, 4'd4, 32'h0, rd);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_rise_suppr: got %h exp 0", rd); end
      xfer(1'b0, 4'd5, 32'h0, rd);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_fall_suppr: got %h exp 0", rd); end
      xfer(1'b0, 4'd3, 32'h0, rd);
      n_checks++; if (rd !== 32'h1FF) begin n_fail++; $display("FAIL rst_din: got %h exp 1ff", rd); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq_after: got %b exp 0", irq); end
   endtask

   task automatic test_roundtrip();
      logic [31:0] rd;
      send(1'b1, 4'd0, 32'h0000_00A5, rd);
      n_checks++; if (dout !== 9'h0A5) begin n_fail++; $display("FAIL rt_dout_pin: got %h exp 0a5", dout); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rt_wr_rdata: got %h exp 0", rd); end
      complete();
      send(1'b1, 4'd1, 32'h0000_0100, rd);
      n_checks++; if (oen !== 9'h100) begin n_fail++; $display("FAIL rt_oen_pin: got %h exp 100", oen); end
      complete();
      xfer(1'b0, 4'd0, 32'h0, rd);
      n_checks++; if (rd !== 32'h0A5) begin n_fail++; $display("FAIL rt_dout_rd: got %h exp 0a5", rd); end
      xfer(1'b0, 4'd1, 32'h0, rd);
      n_checks++; if (rd !== 32'h100) begin n_fail++; $display("FAIL rt_oen_rd: got %h exp 100", rd); end
      xfer(1'b1, 4'd12, $urandom, rd);
      xfer(1'b0, 4'd12, 32'h0, rd);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rt_addr12: got %h exp 0", rd); end
      n_checks++; if (dout !== m_dout || oen !== m_oen) begin n_fail++; $display("FAIL rt_hole_wr: got %h/%h exp %h/%h", dout, oen, m_dout, m_oen); end
   endtask

   task automatic test_cfg();
      logic [31:0] rd;
      xfer(1'b1, 4'd7, 32'd8, rd);
      xfer(1'b1, 4'd8, 32'h0003_FFFF, rd);
      xfer(1'b1, 4'd8, 32'h0000_0001, rd);
      n_checks++; if (tech_cfg[161:144] !== 18'h3FFFF) begin n_fail++; $display("FAIL cfg_pin8: got %h exp 3ffff", tech_cfg[161:144]); end
      n_checks++; if (tech_cfg[17:0] !== 18'h00001) begin n_fail++; $display("FAIL cfg_pin0: got %h exp 00001", tech_cfg[17:0]); end
      n_checks++; if (tech_cfg !== model_cfg_vec()) begin n_fail++; $display("FAIL cfg_vec: got %h exp %h", tech_cfg, model_cfg_vec()); end
      xfer(1'b0, 4'd7, 32'h0, rd);
      n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL cfg_idx_wrap: got %h exp 1", rd); end
      xfer(1'b1, 4'd7, 32'd9, rd);
      xfer(1'b0, 4'd7, 32'h0, rd);
      n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL cfg_idx_ignore: got %h exp 1", rd); end
      xfer(1'b0, 4'd8, 32'h0, rd);
      n_checks++; if (rd !== model_read(4'd8)) begin n_fail++; $display("FAIL cfg_data_rd: got %h exp %h", rd, model_read(4'd8)); end
      xfer(1'b0, 4'd7, 32'h0, rd);
      n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL cfg_rd_noinc: got %h exp 1", rd); end
   endtask

   task automatic test_edge_irq();
      logic [31:0] rd;
      set_din(9'h000);
      xfer(1'b1, 4'd4, 32'h1FF, rd);
      xfer(1'b1, 4'd5, 32'h1FF, rd);
      xfer(1'b1, 4'd6, 32'h004, rd);
      tick();
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_idle: got %b exp 0", irq); end
      // rise on pin 2; read RISE accepted on the 3rd edge sees the old value
      din[2] = 1'b1;
      tick(); tick();
      send(1'b0, 4'd4, 32'h0, rd);
      n_checks++; if (rd[2] !== 1'b0) begin n_fail++; $display("FAIL edge_rise_old: got %b exp 0", rd[2]); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_plus3: got %b exp 0", irq); end
      complete();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq_plus4: got %b exp 1", irq); end
      m_rise[2] = 1'b1;
      xfer(1'b0, 4'd4, 32'h0, rd);
      n_checks++; if (rd !== model_read(4'd4)) begin n_fail++; $display("FAIL edge_rise_rd: got %h exp %h", rd, model_read(4'd4)); end
      set_din(din & ~9'h004);
      xfer(1'b0, 4'd5, 32'h0, rd);
      n_checks++; if (rd !== model_read(4'd5)) begin n_fail++; $display("FAIL edge_fall_rd: got %h exp %h", rd, model_read(4'd5)); end
      xfer(1'b1, 4'd4, 32'h004, rd);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq_fallpend: got %b exp 1", irq); end
      send(1'b1, 4'd5, 32'h004, rd);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq_at_clr: got %b exp 1", irq); end
      complete();
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_cleared: got %b exp 0", irq); end
      // ie[2] = 0 masks detection
      xfer(1'b1, 4'd2, 32'h1FB, rd);
      set_din(din | 9'h004);
      set_din(din & ~9'h004);
      xfer(1'b0, 4'd4, 32'h0, rd);
      n_checks++; if (rd !== model_read(4'd4)) begin n_fail++; $display("FAIL edge_ie_rise: got %h exp %h", rd, model_read(4'd4)); end
      xfer(1'b0, 4'd5, 32'h0, rd);
      n_checks++; if (rd !== model_read(4'd5)) begin n_fail++; $display("FAIL edge_ie_fall: got %h exp %h", rd, model_read(4'd5)); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_ie_irq: got %b exp 0", irq); end
      xfer(1'b1, 4'd2, 32'h1FF, rd);
      // enabling INTEN over an already pending status
      xfer(1'b1, 4'd6, 32'h000, rd);
      set_din(din | 9'h020);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL inten_masked: got %b exp 0", irq); end
      send(1'b1, 4'd6, 32'h020, rd);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL inten_at_acc: got %b exp 0", irq); end
      complete();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL inten_plus1: got %b exp 1", irq); end
   endtask

   task automatic test_collision();
      logic [31:0] rd;
      xfer(1'b1, 4'd4, 32'h1FF, rd);
      xfer(1'b1, 4'd5, 32'h1FF, rd);
      xfer(1'b1, 4'd6, 32'h001, rd);
      set_din(din & ~9'h001);
      set_din(din | 9'h001);
      set_din(din & ~9'h001);
      xfer(1'b1, 4'd5, 32'h1FF, rd);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_pre_irq: got %b exp 1", irq); end
      din[0] = 1'b1;
      tick(); tick();
      send(1'b1, 4'd4, 32'h001, rd);
      m_rise[0] = 1'b1;
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq_acc: got %b exp 1", irq); end
      complete();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL coll_irq_next: got %b exp 1", irq); end
      xfer(1'b0, 4'd4, 32'h0, rd);
      n_checks++; if (rd !== model_read(4'd4)) begin n_fail++; $display("FAIL coll_rise: got %h exp %h", rd, model_read(4'd4)); end
      n_checks++; if (irq !== model_irq()) begin n_fail++; $display("FAIL coll_irq_end: got %b exp %b", irq, model_irq()); end
   endtask

   task automatic test_random_regs();
      logic [31:0] rd, d, exp;
      logic [3:0]  a;
      logic        w;
      for (int n = 0; n < 60; n++) begin
         a = 4'($urandom_range(0, 15));
         w = 1'($urandom_range(0, 1));
         d = (a == 4'd7) ? 32'($urandom_range(0, 15)) : $urandom;
         exp = w ? 32'h0 : model_read(a);
         xfer(w, a, d, rd);
         n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rnd_rdata[%0d]: addr %0d w %b got %h exp %h", n, a, w, rd, exp); end
         n_checks++;
         if (dout !== m_dout || oen !== m_oen || ie !== m_ie || tech_cfg !== model_cfg_vec() || irq !== model_irq()) begin
            n_fail++;
            $display("FAIL rnd_pins[%0d]: got %h %h %h %b exp %h %h %h %b", n, dout, oen, ie, irq, m_dout, m_oen, m_ie, model_irq());
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, exp;
      logic [8:0]  old_dout;
      logic [31:0] nd;
      old_dout = m_dout;
      nd = {23'h0, ~m_dout};
      exp = model_read(4'd0);
      bus_if.resp_ready = 1'b0;
      send(1'b0, 4'd0, 32'h0, rd);
      bus_if.req_valid = 1'b1; bus_if.req_write = 1'b1;
      bus_if.req_addr = 4'd0; bus_if.req_wdata = nd;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++;
         if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== exp || bus_if.req_ready !== 1'b0 || dout !== old_dout) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got v%b d%h r%b p%h exp v1 d%h r0 p%h", k,
                     bus_if.resp_valid, bus_if.resp_rdata, bus_if.req_ready, dout, exp, old_dout);
         end
      end
      bus_if.resp_ready = 1'b1;
      tick();
      n_checks++; if (bus_if.resp_valid !== 1'b0 || dout !== old_dout) begin n_fail++; $display("FAIL bp_release: got v%b p%h exp v0 p%h", bus_if.resp_valid, dout, old_dout); end
      tick();
      bus_if.req_valid = 1'b0;
      model_write(4'd0, nd);
      n_checks++; if (bus_if.resp_valid !== 1'b1 || dout !== m_dout) begin n_fail++; $display("FAIL bp_second: got v%b p%h exp v1 p%h", bus_if.resp_valid, dout, m_dout); end
      complete();
   endtask

   task automatic test_reset_midresp();
      logic [31:0] rd;
      bus_if.resp_ready = 1'b0;
      send(1'b0, 4'd1, 32'h0, rd);
      n_checks++; if (bus_if.resp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b exp 1", bus_if.resp_valid); end
      nreset = 1'b0;
      tick();
      nreset = 1'b1;
      model_reset();
      n_checks++; if (bus_if.resp_valid !== 1'b0 || oen !== m_oen || dout !== m_dout) begin n_fail++; $display("FAIL mid_reset: got v%b %h %h exp v0 %h %h", bus_if.resp_valid, oen, dout, m_oen, m_dout); end
      bus_if.resp_ready = 1'b1;
   endtask

   initial begin
      bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0;
      bus_if.req_addr = 4'd0; bus_if.req_wdata = 32'h0; bus_if.resp_ready = 1'b1;
      model_reset();
      test_reset();
      test_roundtrip();
      test_cfg();
      test_edge_irq();
      test_collision();
      test_random_regs();
      test_backpressure();
      test_reset_midresp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
